// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between the CPU control
// sequencer and the IO/loader engine. Round-robin arbitration, a CPU lock that
// holds the IO requester off the RAM, and four-phase req/ack on both sides.
// MEM_LAT is the RAM read latency and must lie in 1..4.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  // Requester encoding shared by owner and last_grant.
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_IO  = 1'b1;

  // WAIT counter start value: the edge leaving WAIT is MEM_LAT edges after
  // the edge that sampled mem_en, which is when mem_rdata is valid.
  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              io_ack_q, io_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    logic cpu_elig;
    logic io_elig;
    logic grant_io;

    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    owner_d      = owner_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    io_ack_d     = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    io_rdata_d   = io_rdata_q;

    // The lock only gates new IO grants; it never touches a running access.
    cpu_elig = cpu_req;
    io_elig  = io_req & ~cpu_lock;
    // On a tie the requester that did not win last time gets the port.
    grant_io = io_elig & (~cpu_elig | (last_grant_q == GRANT_CPU));

    unique case (state_q)
      S_IDLE: begin
        if (cpu_elig || io_elig) begin
          // Request fields are captured here; later changes are ignored.
          owner_d      = grant_io;
          last_grant_d = grant_io;
          we_d         = grant_io ? io_we    : cpu_we;
          mem_addr_d   = grant_io ? io_addr  : cpu_addr;
          mem_wdata_d  = grant_io ? io_wdata : cpu_wdata;
          mem_en_d     = 1'b1;
          mem_we_d     = grant_io ? io_we    : cpu_we;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          // Writes leave the owner's read-data register untouched.
          if (!we_q) begin
            if (owner_q == GRANT_IO) io_rdata_d  = mem_rdata;
            else                     cpu_rdata_d = mem_rdata;
          end
          cpu_ack_d = (owner_q == GRANT_CPU);
          io_ack_d  = (owner_q == GRANT_IO);
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= GRANT_IO;
      we_q         <= 1'b0;
      owner_q      <= GRANT_CPU;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      io_ack_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      io_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      io_ack_q     <= io_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      io_rdata_q   <= io_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign io_ack    = io_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

  // Port invariants: writes only with the strobe, one ack at a time, and the
  // strobe only ever seen in the single ACCESS cycle of a transaction.
  a_we_needs_en : assert property (@(posedge clk) disable iff (reset) mem_we_q |-> mem_en_q);
  a_one_ack     : assert property (@(posedge clk) disable iff (reset) !(cpu_ack_q && io_ack_q));
  a_en_access   : assert property (@(posedge clk) disable iff (reset) mem_en_q |-> (state_q == S_ACCESS));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic from both requesters, checked by a transaction-level model and a
// scoreboard monitor.
module tb_mem_port_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_lock, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          io_req, io_we, io_ack;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata, io_rdata;
  logic          mem_en, mem_we, owner, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 8'hA5;
    if (a == 255) return 8'h5A;
    if (a == 32) return 8'h00;
    return 8'(a * 37 + 11);
  endfunction

  // RAM with LAT-cycle read latency; output is poisoned outside valid cycles.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_pipe [LAT];
  bit            ram_loaded = 1'b0;
  assign mem_rdata = rd_pipe[LAT-1];
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'hEE;
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int            at;
    logic          who;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  int            cur = 0;
  int            free_at = 0;
  int            g_edge = 0;
  bit            g_valid = 1'b0;
  int            rst_cnt = 0;
  bit            m_loaded = 1'b0;
  logic          m_last = 1'b1, m_owner = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] mdl_mem [256];
  logic [DW-1:0] held [2];

  // The port is a single server: it accepts one request at an idle sampling
  // edge, acks 1+LAT edges later and is free again 3+LAT edges after grant.
  always @(posedge clk) begin : model
    logic ce, ie, gio;
    exp_t e;
    cur++;
    if (!m_loaded) begin
      for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
      m_loaded = 1'b1;
    end
    if (reset) begin
      free_at = cur + 1; g_valid = 1'b0; m_last = 1'b1; m_owner = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; held[0] = '0; held[1] = '0;
      exp_q.delete(); rst_cnt++;
    end else if (cur >= free_at) begin
      ce = cpu_req;
      ie = io_req && !cpu_lock;
      if (ce || ie) begin
        gio = ie && (!ce || !m_last);
        m_owner = gio; m_last = gio;
        m_we    = gio ? io_we    : cpu_we;
        m_addr  = gio ? io_addr  : cpu_addr;
        m_wdata = gio ? io_wdata : cpu_wdata;
        if (m_we) mdl_mem[m_addr] = m_wdata;
        else      held[gio] = mdl_mem[m_addr];
        e.at = cur + 1 + LAT; e.who = gio; e.rdata = held[gio];
        exp_q.push_back(e);
        g_edge = cur; g_valid = 1'b1; free_at = cur + 3 + LAT;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [DW-1:0] vis [2];
  int            seen_rst = 0;
  int            ack_at[$];
  logic          ack_who[$];
  int            io_ack_cnt = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ea;
    logic en_x, busy_x;
    if (cur != 0) begin
      if (rst_cnt != seen_rst) begin vis[0] = '0; vis[1] = '0; seen_rst = rst_cnt; end
      ea = 1'b0; e.at = 0; e.who = 1'b0; e.rdata = '0;
      if (exp_q.size() != 0 && exp_q[0].at == cur) begin
        e = exp_q.pop_front(); ea = 1'b1; vis[e.who] = e.rdata;
      end
      en_x   = g_valid && (cur == g_edge);
      busy_x = g_valid && (cur >= g_edge) && (cur <= g_edge + 1 + LAT);
      chk("cpu_ack",   32'(cpu_ack),   32'(ea && !e.who));
      chk("io_ack",    32'(io_ack),    32'(ea && e.who));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(vis[0]));
      chk("io_rdata",  32'(io_rdata),  32'(vis[1]));
      chk("mem_en",    32'(mem_en),    32'(en_x));
      chk("mem_we",    32'(mem_we),    32'(en_x && m_we));
      chk("mem_addr",  32'(mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("owner",     32'(owner),     32'(m_owner));
      chk("busy",      32'(busy),      32'(busy_x));
      if (cpu_ack) begin ack_at.push_back(cur); ack_who.push_back(1'b0); end
      if (io_ack) begin ack_at.push_back(cur); ack_who.push_back(1'b1); io_ack_cnt++; end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic txn(input logic who, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input bit scramble);
    int n;
    bit got;
    if (who) begin io_we = we; io_addr = addr; io_wdata = wd; io_req = 1'b1; end
    else begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; end
    n = 0; got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      got = who ? io_ack : cpu_ack;
      if (!got && scramble && $urandom_range(0, 3) == 0) begin
        if (who) begin io_addr = 8'($urandom_range(0, 31)); io_wdata = 8'($urandom); end
        else begin cpu_addr = 8'($urandom_range(0, 31)); cpu_wdata = 8'($urandom); end
      end
    end
    if (who) io_req = 1'b0; else cpu_req = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL ack_timeout: requester %0d saw no ack in 400 cycles, required one", who);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_loop(input logic who, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      txn(who, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom), 1'b1);
    end
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int io_before;
    bit cpu_done, io_done;
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_lock = 0;
    io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_owner", 32'(owner), 32'h0);
    @(posedge clk); #1;

    // Single CPU read of a preloaded word.
    txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'hA5);

    // IO write then read back.
    txn(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);
    txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    chk("t2_io_rdata", 32'(io_rdata), 32'h3C);

    // Both requesting continuously right after reset: strict alternation.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    ack_who.delete(); ack_at.delete();
    fork
      repeat (3) txn(1'b0, 1'b0, 8'h30, 8'h00, 1'b0);
      repeat (3) txn(1'b1, 1'b1, 8'h31, 8'h44, 1'b0);
    join
    chk("t3_ack_count", 32'(ack_who.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_who.size(); i++) chk("t3_owner_seq", 32'(ack_who[i]), 32'(i % 2));
    for (int i = 1; i < 6 && i < ack_at.size(); i++) chk("t3_ack_spacing", 32'(ack_at[i] - ack_at[i-1]), 32'(3 + LAT));

    // Lock keeps IO waiting while the CPU is served twice.
    io_before = io_ack_cnt;
    fork
      txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
      begin
        cpu_lock = 1'b1;
        txn(1'b0, 1'b0, 8'h05, 8'h00, 1'b0);
        txn(1'b0, 1'b1, 8'h06, 8'h99, 1'b0);
        chk("t4_io_blocked", 32'(io_ack_cnt - io_before), 32'd0);
        cpu_lock = 1'b0;
      end
    join
    chk("t4_io_served", 32'(io_ack_cnt - io_before), 32'd1);

    // Reset in WAIT of a CPU read aborts it; CPU then wins the next tie.
    txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    chk("t5_pre_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_no_ack", 32'(cpu_ack), 32'h0);
    chk("t5_rdata_cleared", 32'(cpu_rdata), 32'h0);
    chk("t5_idle", 32'(busy), 32'h0);
    @(posedge clk); #1;
    ack_who.delete(); ack_at.delete();
    fork
      txn(1'b0, 1'b0, 8'h11, 8'h00, 1'b0);
      txn(1'b1, 1'b0, 8'h12, 8'h00, 1'b0);
    join
    chk("t5_acks", 32'(ack_who.size()), 32'd2);
    if (ack_who.size() > 0) chk("t5_cpu_first", 32'(ack_who[0]), 32'h0);

    // Long-latency read of the top address.
    txn(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
    chk("t6_cpu_rdata", 32'(cpu_rdata), 32'h5A);

    // Request dropped and address changed right after grant: still acked,
    // and the write lands at the address captured at grant.
    cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h77; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 8'h41; cpu_wdata = 8'h00;
    io_before = 0;
    for (int i = 0; i < 20 && io_before == 0; i++) begin
      @(negedge clk);
      if (cpu_ack) io_before = 1;
    end
    chk("t7_ack_after_drop", 32'(io_before), 32'd1);
    @(posedge clk); #1;
    txn(1'b0, 1'b0, 8'h40, 8'h00, 1'b0);
    chk("t7_latched_write", 32'(cpu_rdata), 32'h77);

    // Randomized traffic from both sides with a toggling lock.
    cpu_done = 1'b0; io_done = 1'b0;
    fork
      begin rand_loop(1'b0, 60); cpu_done = 1'b1; end
      begin rand_loop(1'b1, 60); io_done = 1'b1; end
      begin
        while (!(cpu_done && io_done)) begin
          @(posedge clk); #1;
          if ($urandom_range(0, 7) == 0) cpu_lock = ~cpu_lock;
        end
        cpu_lock = 1'b0;
      end
    join

    repeat (12) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous RAM port between two requesters: the CPU control sequencer and the IO/loader engine.
- Each transaction is a read or write of one word. A four-phase req/ack handshake is used on each side.
- The arbiter sits between the requesters and the RAM. It owns every RAM control signal and returns read data with a one-cycle ack pulse.
- Arbitration is round-robin. The CPU can hold a lock that keeps the IO requester off the RAM during multi-cycle instructions.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- MEM_LAT, 1, RAM read latency in cycles, measured from the edge that samples mem_en to valid mem_rdata. Legal range is 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU transaction request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_lock  in  1  while high, new IO grants are blocked.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid when cpu_ack is high and held until the next CPU ack.
- io_req, io_we, io_addr, io_wdata, io_ack, io_rdata: the same set of signals for the IO requester.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable; only high together with mem_en.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- owner  out  1  owner of the current or last transaction: 0 = CPU, 1 = IO.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - cpu_ack, io_ack, mem_en, mem_we, busy = 0.
  - mem_addr, mem_wdata, cpu_rdata, io_rdata = 0.
  - owner = 0.
  - last_grant = IO, so the CPU wins the first tie.
- States: IDLE -> ACCESS -> WAIT (MEM_LAT cycles, counter) -> ACK -> IDLE.
- IDLE:
  - Eligible requesters: cpu_req; io_req only when cpu_lock = 0.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the one that is not last_grant.
  - On grant: latch we/addr/wdata into mem_*, set owner, update last_grant, go to ACCESS.
  - If nothing is eligible, stay in IDLE.
- ACCESS:
  - Exactly one cycle with mem_en = 1; mem_we = latched we.
  - The write commits at the edge that ends ACCESS.
  - Go to WAIT with counter = MEM_LAT-1.
- WAIT:
  - mem_en = 0 and mem_we = 0; mem_addr holds its value.
  - While counter != 0, decrement it.
  - When counter == 0: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), then go to ACK.
- ACK:
  - Owner's ack = 1 for exactly one cycle, then return to IDLE.
  - The other ack stays 0 throughout.
- Latency:
  - req sampled high at edge E0 -> ack high in the cycle after edge E0+2+MEM_LAT-1, i.e. 2+MEM_LAT cycles after grant.
  - Reads and writes take the same time.
- Back-to-back requests:
  - A requester must drop req in the ack cycle; it may re-raise req in the following cycle.
  - The IDLE cycle after ACK is mandatory, so the minimum transaction period is 3+MEM_LAT cycles.
  - With both requesters continuously requesting, grants strictly alternate: CPU, IO, CPU, ...
- cpu_lock:
  - Checked only in IDLE.
  - Asserting it during an IO transaction does not abort that transaction.
  - While it is high, a pending io_req waits indefinitely; the CPU is still served.
- Protocol violations:
  - A requester that drops req mid-transaction still gets its ack pulse and the access still happens.
  - A req whose address or data changes after grant has no effect; the values latched at grant are used.
- Reset mid-transaction:
  - The next edge forces IDLE with all reset values.
  - Reset during ACCESS suppresses nothing retroactively: mem_en was already high for that cycle.
  - No ack is issued for an aborted transaction.
  - last_grant reinitialises to IO.
- Assertions:
  - mem_we implies mem_en.
  - cpu_ack and io_ack are never high together.
  - At most one mem_en pulse per transaction.

Test Plan:
- Single CPU read, MEM_LAT=1, RAM[0x10]=0xA5: cpu_req/addr 0x10 at cycle 0 -> mem_en=1 with mem_addr=0x10 in cycle 1; cpu_ack=1 with cpu_rdata=0xA5 in cycle 3; busy high in cycles 1-3.
- IO write 0x3C to 0x20, then IO read of 0x20 -> exactly one mem_en&mem_we pulse; io_ack on the write; read returns io_rdata=0x3C; cpu_ack never asserted.
- Both requesters held high from reset for 6 transactions -> owner sequence 0,1,0,1,0,1; ack pulses are 4 cycles apart (MEM_LAT=1).
- cpu_lock=1 with io_req and cpu_req both high -> two CPU transactions are served and IO waits; drop cpu_lock -> the IO grant follows in the next IDLE.
- Assert reset in the WAIT cycle of a CPU read -> the next cycle has state IDLE, no cpu_ack, cpu_rdata=0; a subsequent simultaneous request is granted to the CPU.
- MEM_LAT=3 read of RAM[0xFF]=0x5A -> ack 5 cycles after grant with cpu_rdata=0x5A; mem_en high for 1 cycle only.
